// File: rtl/pencoder_pkg.sv
// Shared definitions for the registered priority encoder.
// Index-width helper, reset index value and the index type for the default configuration.
package pencoder_pkg;

   localparam int PENCODER_RST_IDX = 0;
   localparam int PENCODER_N_DEF   = 8;

   // Same result as $clog2 for n >= 2; written out so it can size package types.
   function automatic int pencoder_idx_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   typedef logic [pencoder_idx_w(PENCODER_N_DEF)-1:0] pencoder_idx_t;

endpackage

// File: rtl/pencoder_n_comb.sv
// Combinational MSB-first priority encoder: N-bit vector in, index of highest set bit
// plus an any-bit-set flag out.
module pencoder_n_comb
   import pencoder_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = pencoder_idx_w(N)
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pencoder_n_reg.sv
// Registered N-input priority encoder with request capture and valid/ready output slot.
// Define PENCODER_RR_EN for rotating priority; otherwise fixed MSB-first priority.
module pencoder_n_reg
   import pencoder_pkg::*;
#(
   parameter  int N     = 8,
   localparam int IDX_W = pencoder_idx_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   output logic [N-1:0]     pending,
   output logic             merged,
   output logic             busy
);

   logic             accept;
   logic             load;
   logic [N-1:0]     load_onehot;
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] ridx;
   logic             rany;
   logic [IDX_W-1:0] sel;

   pencoder_n_comb #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_comb (
      .vec (rot),
      .idx (ridx),
      .any (rany)
   );

`ifdef PENCODER_RR_EN
   logic [IDX_W-1:0] last;
   logic [IDX_W:0]   sum;

   // Rotate so pending[last-1] lands on the MSB; pending[last] ends up lowest priority.
   always_comb begin
      rot = '0;
      for (int j = 0; j < N; j++) begin
         rot[j] = pending[(j + int'(last)) % N];
      end
      sum = {1'b0, ridx} + {1'b0, last};
      if (sum >= (IDX_W+1)'(N)) begin
         sel = IDX_W'(sum - (IDX_W+1)'(N));
      end else begin
         sel = sum[IDX_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last <= '0;
      end else if (load) begin
         last <= sel;
      end
   end
`else
   always_comb begin
      rot = pending;
      sel = ridx;
   end
`endif

   always_comb begin
      accept      = out_valid && out_ready;
      load        = (!out_valid || accept) && rany;
      load_onehot = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
      busy        = (|pending) || out_valid;
   end

   // Request capture: set wins over the clear of a bit being moved to the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         merged  <= 1'b0;
      end else begin
         pending <= (pending & ~load_onehot) | req;
         merged  <= |(req & pending & ~load_onehot);
      end
   end

   // Output slot: refills on the accepting edge; out_idx holds its value when emptied.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_idx   <= IDX_W'(PENCODER_RST_IDX);
      end else if (load) begin
         out_valid <= 1'b1;
         out_idx   <= sel;
      end else if (accept) begin
         out_valid <= 1'b0;
      end
   end

endmodule
